// File: rtl/gray2bin_pkg.sv
// Shared types and helpers for the time-multiplexed Gray-to-binary converter
// and its round-robin arbiter.
package gray2bin_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONV,
      ST_RESP
   } state_t;

   localparam int GMAX = 64;

   function automatic int idw_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Whole-word reference conversion; narrower codewords are zero-extended.
   function automatic logic [GMAX-1:0] gray2bin(input logic [GMAX-1:0] g);
      logic [GMAX-1:0] b;
      b[GMAX-1] = g[GMAX-1];
      for (int i = GMAX - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_arb_if.sv
// Request/response bundle between NREQ Gray-code producers, the shared
// converter and the result consumer.
interface gray2bin_arb_if
   import gray2bin_pkg::*;
#(
   parameter int SIZE = 8,
   parameter int NREQ = 4,
   parameter int IDW  = idw_f(NREQ)
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*SIZE-1:0] req_gray;
   logic [NREQ-1:0]      req_ready;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [SIZE-1:0]      rsp_bin;
   logic [IDW-1:0]       rsp_id;

   modport master (
      output req_valid, req_gray, rsp_ready,
      input  req_ready, rsp_valid, rsp_bin, rsp_id
   );

   modport slave (
      input  req_valid, req_gray, rsp_ready,
      output req_ready, rsp_valid, rsp_bin, rsp_id
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from
// last+1, wrapping modulo NREQ.
module rr_arbiter
   import gray2bin_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IDW = idw_f(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx
);

   logic found;

   // Pass one covers indices above last, pass two wraps to 0..last.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[i] && (i > int'(last))) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
            idx    = IDW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[i] && (i <= int'(last))) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
            idx    = IDW'(i);
         end
      end
   end

endmodule

// File: rtl/gray2bin_arb.sv
// Shared Gray-to-binary converter: round-robin grants one requester, resolves
// its codeword MSB-first one bit per cycle, then holds the result until taken.
module gray2bin_arb
   import gray2bin_pkg::*;
#(
   parameter int SIZE = 8,
   parameter int NREQ = 4
) (
   input logic           clk,
   input logic           rst_n,
   gray2bin_arb_if.slave bus
);

   localparam int IDW = idw_f(NREQ);
   localparam int CW  = (SIZE > 1) ? $clog2(SIZE) : 1;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [SIZE-1:0] g, g_pick;
   logic [SIZE-1:0] acc, acc_nxt;
   logic [SIZE:0]   accx;
   logic [IDW-1:0]  id, last, pick_idx;
   logic [NREQ-1:0] pick_gnt;
   logic            rsp_valid_q;
   logic            take;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req  (bus.req_valid),
      .last (last),
      .gnt  (pick_gnt),
      .idx  (pick_idx)
   );

   assign bus.req_ready = (state == ST_IDLE && rst_n) ? pick_gnt : '0;
   assign take          = |(bus.req_valid & bus.req_ready);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_bin   = acc;
   assign bus.rsp_id    = id;

   // The zero above the MSB lets the top bit use the same XOR as the rest.
   always_comb begin
      g_pick  = '0;
      accx    = {1'b0, acc};
      acc_nxt = acc;
      for (int k = 0; k < NREQ; k++) begin
         if (pick_gnt[k]) g_pick = bus.req_gray[k*SIZE +: SIZE];
      end
      for (int i = 0; i < SIZE; i++) begin
         if (cnt == CW'(i)) acc_nxt[i] = accx[i+1] ^ g[i];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (take)            state_nxt = ST_CONV;
         ST_CONV: if (cnt == '0)       state_nxt = ST_RESP;
         ST_RESP: if (bus.rsp_ready)   state_nxt = ST_IDLE;
         default:                      state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         last        <= IDW'(NREQ - 1);
         cnt         <= '0;
         acc         <= '0;
         id          <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         rsp_valid_q <= (state_nxt == ST_RESP);
         case (state)
            ST_IDLE: begin
               if (take) begin
                  id  <= pick_idx;
                  cnt <= CW'(SIZE - 1);
               end
            end
            ST_CONV: begin
               acc <= acc_nxt;
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            ST_RESP: begin
               if (bus.rsp_ready) last <= id;
            end
            default: ;
         endcase
      end
   end

   // Codeword register is pure data and needs no reset.
   always_ff @(posedge clk) begin
      if (take) g <= g_pick;
   end

endmodule

// File: tb/tb_gray2bin_arb.sv
// Directed bench for gray2bin_arb: latency, arbitration order, backpressure,
// mid-conversion reset, fairness, and a full 8-bit sweep on a single-requester copy.
module tb_gray2bin_arb;
   import gray2bin_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gray2bin_arb_if #(.SIZE(8), .NREQ(4)) bus  ();
   gray2bin_arb_if #(.SIZE(8), .NREQ(1)) bus1 ();

   gray2bin_arb #(.SIZE(8), .NREQ(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   gray2bin_arb #(.SIZE(8), .NREQ(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input int maxc);
      for (int w = 0; w < maxc && bus.rsp_valid !== 1'b1; w++) tick();
      chk("rsp_timeout", 32'(bus.rsp_valid), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp2 [4];
      int         seq5 [5];
      logic [7:0] exp5 [5];
      logic [7:0] e8;
      int         prev, nreq, nrsp, rr;
      logic       done;

      exp2 = '{8'hFF, 8'h01, 8'h00, 8'hAA};
      seq5 = '{1, 3, 1, 3, 1};
      exp5 = '{8'hAA, 8'hFF, 8'hAA, 8'hFF, 8'hAA};
      prev = 0;
      nreq = 0;
      nrsp = 0;

      bus.req_valid  = 4'hF;
      bus.req_gray   = '0;
      bus.rsp_ready  = 1'b0;
      bus1.req_valid = 1'b0;
      bus1.req_gray  = '0;
      bus1.rsp_ready = 1'b0;

      // Reset state, with requests asserted to see req_ready held low.
      tick(); tick(); tick();
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_bin",   32'(bus.rsp_bin), 0);
      chk("rst_rsp_id",    32'(bus.rsp_id), 0);
      chk("rst_req_ready", 32'(bus.req_ready), 0);

      // Single request: C3 -> 82, response exactly at t+9.
      bus.req_valid = 4'b0001;
      bus.req_gray  = {8'h00, 8'h00, 8'h00, 8'hC3};
      bus.rsp_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      chk("t1_grant", 32'(bus.req_ready), 32'b0001);
      tick();
      bus.req_valid = 4'hF;
      for (int i = 1; i <= 8; i++) begin
         #1;
         chk("t1_conv_valid", 32'(bus.rsp_valid), 0);
         chk("t1_conv_ready", 32'(bus.req_ready), 0);
         tick();
      end
      bus.req_valid = 4'h0;
      #1;
      chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("t1_rsp_bin",   32'(bus.rsp_bin), 32'h82);
      chk("t1_rsp_id",    32'(bus.rsp_id), 0);
      chk("t1_rsp_ready", 32'(bus.req_ready), 0);
      tick();
      chk("t1_after_valid", 32'(bus.rsp_valid), 0);

      // All four valid from reset: id order 0..3, ten cycles apart.
      rst_n = 1'b0;
      bus.req_valid = 4'hF;
      bus.req_gray  = {8'hFF, 8'h00, 8'h01, 8'h80};
      tick(); tick();
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         #1;
         chk("t2_grant", 32'(bus.req_ready), 32'(1 << n));
         tick();
         bus.req_valid[n] = 1'b0;
         wait_rsp(20);
         chk("t2_id",  32'(bus.rsp_id), 32'(n));
         chk("t2_bin", 32'(bus.rsp_bin), 32'(exp2[n]));
         if (n > 0) chk("t2_spacing", 32'(cyc - prev), 10);
         prev = cyc;
         tick();
      end

      // Backpressure: five stalled RESP cycles on requester 2 (5A -> 6C).
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0100;
      bus.req_gray  = {8'h00, 8'h5A, 8'h00, 8'h00};
      #1;
      chk("t3_grant", 32'(bus.req_ready), 32'b0100);
      tick();
      bus.req_valid = 4'b0001;
      bus.req_gray[7:0] = 8'h01;
      wait_rsp(20);
      for (int s = 0; s < 5; s++) begin
         #1;
         chk("t3_stall_valid", 32'(bus.rsp_valid), 1);
         chk("t3_stall_bin",   32'(bus.rsp_bin), 32'h6C);
         chk("t3_stall_id",    32'(bus.rsp_id), 2);
         chk("t3_stall_ready", 32'(bus.req_ready), 0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("t3_release_valid", 32'(bus.rsp_valid), 1);
      tick();
      #1;
      chk("t3_idle_valid", 32'(bus.rsp_valid), 0);
      chk("t3_idle_grant", 32'(bus.req_ready), 32'b0001);
      tick();
      bus.req_valid = 4'b0000;
      wait_rsp(20);
      chk("t3_next_id",  32'(bus.rsp_id), 0);
      chk("t3_next_bin", 32'(bus.rsp_bin), 32'h01);
      tick();

      // Reset during the third CONV cycle aborts the conversion.
      bus.req_valid = 4'b0010;
      bus.req_gray  = {8'h80, 8'h00, 8'hFF, 8'h3C};
      #1;
      chk("t4_grant", 32'(bus.req_ready), 32'b0010);
      tick();
      bus.req_valid = 4'b0000;
      tick();
      tick();
      bus.req_valid = 4'hF;
      rst_n = 1'b0;
      #1;
      chk("t4_rst_valid", 32'(bus.rsp_valid), 0);
      chk("t4_rst_bin",   32'(bus.rsp_bin), 0);
      chk("t4_rst_id",    32'(bus.rsp_id), 0);
      chk("t4_rst_ready", 32'(bus.req_ready), 0);
      tick();
      chk("t4_rst_hold_valid", 32'(bus.rsp_valid), 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("t4_first_grant", 32'(bus.req_ready), 32'b0001);
      tick();
      bus.req_valid = 4'b1010;
      wait_rsp(20);
      chk("t4_id",  32'(bus.rsp_id), 0);
      chk("t4_bin", 32'(bus.rsp_bin), 32'h28);
      tick();

      // Fairness: requesters 1 and 3 stay valid and alternate.
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t5_grant", 32'(bus.req_ready), 32'(1 << seq5[k]));
         tick();
         wait_rsp(20);
         chk("t5_id",  32'(bus.rsp_id), 32'(seq5[k]));
         chk("t5_bin", 32'(bus.rsp_bin), 32'(exp5[k]));
         tick();
      end
      bus.req_valid = 4'b0000;

      // Single-requester sweep of every codeword with random consumer stalls.
      for (int gv = 0; gv < 256; gv++) begin
         bus1.req_gray  = 8'(gv);
         bus1.req_valid = 1'b1;
         #1;
         chk("t6_ready", 32'(bus1.req_ready), 1);
         tick();
         bus1.req_valid = 1'b0;
         nreq++;
         e8   = 8'(gray2bin(64'(gv)));
         done = 1'b0;
         for (int w = 0; w < 60 && !done; w++) begin
            if (bus1.rsp_valid === 1'b1) begin
               rr = $urandom_range(0, 1);
               bus1.rsp_ready = rr[0];
               if (rr[0]) begin
                  chk("t6_bin", 32'(bus1.rsp_bin), 32'(e8));
                  chk("t6_id",  32'(bus1.rsp_id), 0);
                  nrsp++;
                  done = 1'b1;
               end
            end else begin
               bus1.rsp_ready = 1'b0;
            end
            tick();
         end
         bus1.rsp_ready = 1'b0;
         chk("t6_done", 32'(done), 1);
      end
      chk("t6_count", 32'(nrsp), 32'(nreq));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
